// File: rtl/gcd_core_pkg.sv
// Shared types for the subtractive-Euclid GCD engine.
package gcd_core_pkg;

  // Controller state encoding: IDLE=0, BUSY=1, DONE=2.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_core_step.sv
// One subtractive-Euclid step: decides completion or subtracts the smaller
// working value from the larger one. Purely combinational.
module gcd_step #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rb,
  output logic [DATA_WIDTH-1:0] ra_nxt,
  output logic [DATA_WIDTH-1:0] rb_nxt,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  // Priority: equality, then either operand zero, then larger-minus-smaller.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    ra_nxt = ra;
    rb_nxt = rb;
    done   = 1'b0;
    result = ra;
    if (ra == rb) begin
      done   = 1'b1;
      result = ra;
    end else if (ra == '0) begin
      done   = 1'b1;
      result = rb;
    end else if (rb == '0) begin
      done   = 1'b1;
      result = ra;
    end else if (ra > rb) begin
      ra_nxt = ra - rb;
    end else begin
      rb_nxt = rb - ra;
    end
  end

endmodule

// File: rtl/gcd_core.sv
// Iterative GCD engine: one subtraction per clock, registered result and
// level valid. Holds the FSM and working registers; the step logic lives
// in gcd_step.
module gcd_core
  import gcd_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] y
);

  state_t                state;
  logic [DATA_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rb;
  logic [DATA_WIDTH-1:0] ra_nxt;
  logic [DATA_WIDTH-1:0] rb_nxt;
  logic                  step_done;
  logic [DATA_WIDTH-1:0] step_result;

  gcd_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .ra     (ra),
    .rb     (rb),
    .ra_nxt (ra_nxt),
    .rb_nxt (rb_nxt),
    .done   (step_done),
    .result (step_result)
  );

  // Controller: accept a request when idle or done, iterate while busy,
  // publish y and valid together on completion.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      y     <= '0;
      ra    <= '0;
      rb    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (enable) begin
            ra    <= a;
            rb    <= b;
            valid <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // A new enable here is deliberately ignored; operands stay put.
          if (step_done) begin
            y     <= step_result;
            valid <= 1'b1;
            state <= DONE;
          end else begin
            ra <= ra_nxt;
            rb <= rb_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core at DATA_WIDTH=9: scoreboard of expected
// results and latencies from a division-based Euclid reference model.
module tb_gcd_core;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         valid;
  logic [W-1:0] y;

  gcd_core #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .a      (a),
    .b      (b),
    .valid  (valid),
    .y      (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp_y;
    int exp_lat;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   last_y = 0;
  logic prev_v = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference gcd by remainder Euclid.
  function automatic int ref_gcd(input int x, input int v);
    int t;
    while (v != 0) begin
      t = x % v;
      x = v;
      v = t;
    end
    return x;
  endfunction

  // Number of subtractions the subtractive method needs: each division step
  // with quotient q costs q subtractions, except the last which stops at equality.
  function automatic int ref_steps(input int x, input int v);
    int s;
    int t;
    if (x == 0 || v == 0) return 0;
    s = 0;
    while (v != 0) begin
      s += x / v;
      t = x % v;
      x = v;
      v = t;
    end
    return s - 1;
  endfunction

  // Monitor: on each rising valid, pop and compare result and latency.
  always @(negedge clk) begin
    if (valid && !prev_v) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: y=%0d with empty scoreboard", y);
      end else begin
        mon_e = sb.pop_front();
        check("result_y", int'(y), mon_e.exp_y);
        check("latency", cyc - mon_e.acc_cyc, mon_e.exp_lat);
      end
    end
    prev_v = valid;
  end

  // Called at a negedge; drives a one-cycle enable and returns at the next negedge.
  task automatic issue(input int x, input int v, input bit track);
    a      = x[W-1:0];
    b      = v[W-1:0];
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("valid_low_after_enable", int'(valid), 0);
    check("y_hold_after_enable", int'(y), last_y);
    if (track) begin
      sb.push_back('{ref_gcd(x, v), ref_steps(x, v) + 1, cyc});
      last_y = ref_gcd(x, v);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid: timeout after %0d cycles, valid=%0d", n, valid);
    end
  endtask

  int dir_a[10] = '{9, 49, 40, 250, 250, 19, 25, 0, 12, 0};
  int dir_b[10] = '{27, 21, 40, 190, 5, 27, 30, 12, 0, 0};

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_valid", int'(valid), 0);
    check("reset_y", int'(y), 0);

    // Directed pairs, issued back-to-back on the first DONE cycle.
    for (int i = 0; i < 10; i++) begin
      issue(dir_a[i], dir_b[i], 1'b1);
      wait_valid();
    end

    // Enable while busy must be ignored.
    issue(250, 190, 1'b1);
    repeat (2) @(negedge clk);
    a      = 9'd5;
    b      = 9'd7;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_valid();

    // Reset in the middle of a computation.
    issue(250, 5, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_valid", int'(valid), 0);
    check("midreset_y", int'(y), 0);
    last_y = 0;
    repeat (3) @(negedge clk);
    check("idle_after_reset_valid", int'(valid), 0);
    issue(49, 21, 1'b1);
    wait_valid();

    // Worst case for 9 bits.
    issue(511, 1, 1'b1);
    wait_valid();

    // Random operand pairs.
    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 1'b1);
      wait_valid();
    end

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
